hamming74_rx_sequencer: RTL and testbench

Receive-side controller for the Hamming(7,4) UART link. It frames the serial line into start / 7 code bits / stop, and runs single-error correction on each 7-bit codeword. It pairs two corrected nibbles into a byte and presents the byte on a valid/ready interface. It sits between the baud-rate strobe generator and the byte consumer, and replaces free-running capture with an explicit frame state machine.

---
 rtl/hamming74_rx_sequencer_if.sv | 27 ++
 rtl/hamming74_rx_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_hamming74_rx_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming74_rx_sequencer_if.sv
// Purpose: bundles the receiver's line-side inputs, byte handshake and status outputs.
// Latency: none. This file holds wiring only.
// Backpressure: byte_valid/byte_ready; the sequencer drops a completed byte while the holding register is full.
interface hamming74_rx_sequencer_if;
    logic       ena;
    logic       bit_en;
    logic       rx_in;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       corrected;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    // Environment side: drives the serial line and consumes bytes
    modport master (
        output ena, bit_en, rx_in, byte_ready,
        input  byte_out, byte_valid, corrected, frame_err, overflow, busy
    );

    // Receiver side
    modport slave (
        input  ena, bit_en, rx_in, byte_ready,
        output byte_out, byte_valid, corrected, frame_err, overflow, busy
    );
endinterface

// File: rtl/hamming74_rx_sequencer.sv
// Purpose: frames start/7 code bits/stop, corrects single errors and pairs nibbles into bytes.
// Latency: byte_valid rises the cycle after the edge that samples the second codeword's stop bit.
// Backpressure: a single holding register; a byte that completes while the register is full and not being consumed is dropped and overflow pulses.
module hamming74_rx_sequencer (
    input  logic                      clk,
    input  logic                      rst_n,
    hamming74_rx_sequencer_if.slave   rx_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:1] code_q, code_d;
    logic       pend_q, pend_d;
    logic [3:0] lo_nib_q, lo_nib_d;
    logic       lo_corr_q, lo_corr_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       corr_q, corr_d;
    logic       ferr_q, ferr_d;
    logic       ovf_q, ovf_d;

    // Per-strobe control decoded from the frame state
    logic       start_hit;
    logic       data_hit;
    logic       stop_ok;
    logic       stop_bad;

    // Decoder results for the captured codeword
    logic [2:0] syn;
    logic [7:1] fixed;
    logic [3:0] nib;
    logic       had_err;

    logic [2:0] wr_idx;
    logic       accept;

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next frame state; the state moves only on sample strobes, and a low enable forces IDLE
    always_comb begin
        state_d = state_q;
        if (!rx_if.ena) begin
            state_d = ST_IDLE;
        end else if (rx_if.bit_en) begin
            case (state_q)
                ST_IDLE: if (!rx_if.rx_in) state_d = ST_DATA;
                ST_DATA: if (cnt_q == 3'd6) state_d = ST_STOP;
                ST_STOP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Per-strobe control pulses for the datapath
    always_comb begin
        start_hit = 1'b0;
        data_hit  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        if (rx_if.ena && rx_if.bit_en) begin
            case (state_q)
                ST_IDLE: start_hit = ~rx_if.rx_in;
                ST_DATA: data_hit  = 1'b1;
                ST_STOP: begin
                    stop_ok  = rx_if.rx_in;
                    stop_bad = ~rx_if.rx_in;
                end
                default: ;
            endcase
        end
    end

    assign wr_idx = cnt_q + 3'd1;

    // Bit counter and codeword capture; c1 lands in position 1
    always_comb begin
        cnt_d  = cnt_q;
        code_d = code_q;
        if (!rx_if.ena || start_hit) begin
            cnt_d = 3'd0;
        end else if (data_hit) begin
            code_d[wr_idx] = rx_if.rx_in;
            cnt_d          = cnt_q + 3'd1;
        end
    end

    // Syndrome decode and single-bit correction
    always_comb begin
        syn[0] = code_q[1] ^ code_q[3] ^ code_q[5] ^ code_q[7];
        syn[1] = code_q[2] ^ code_q[3] ^ code_q[6] ^ code_q[7];
        syn[2] = code_q[4] ^ code_q[5] ^ code_q[6] ^ code_q[7];
        fixed  = code_q;
        if (syn != 3'd0) begin
            fixed[syn] = ~code_q[syn];
        end
        had_err = (syn != 3'd0);
        nib     = {fixed[7], fixed[6], fixed[5], fixed[3]};
    end

    assign accept = valid_q & rx_if.byte_ready;

    // Nibble pairing, byte holding register and status pulses
    always_comb begin
        pend_d    = pend_q;
        lo_nib_d  = lo_nib_q;
        lo_corr_d = lo_corr_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        corr_d    = corr_q;
        ferr_d    = 1'b0;
        ovf_d     = 1'b0;

        if (accept) begin
            valid_d = 1'b0;
        end

        if (!rx_if.ena) begin
            pend_d = 1'b0;
        end else if (stop_bad) begin
            ferr_d = 1'b1;
            pend_d = 1'b0;
        end else if (stop_ok) begin
            if (!pend_q) begin
                lo_nib_d  = nib;
                lo_corr_d = had_err;
                pend_d    = 1'b1;
            end else begin
                pend_d = 1'b0;
                // A byte being consumed on this same edge frees the slot
                if (!valid_q || accept) begin
                    byte_d  = {nib, lo_nib_q};
                    corr_d  = had_err | lo_corr_q;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 3'd0;
            code_q    <= 7'd0;
            pend_q    <= 1'b0;
            lo_nib_q  <= 4'd0;
            lo_corr_q <= 1'b0;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            corr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            pend_q    <= pend_d;
            lo_nib_q  <= lo_nib_d;
            lo_corr_q <= lo_corr_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            corr_q    <= corr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_if.byte_out   = byte_q;
    assign rx_if.byte_valid = valid_q;
    assign rx_if.corrected  = corr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overflow   = ovf_q;
    assign rx_if.busy       = (state_q != ST_IDLE) | pend_q;

endmodule

// File: tb/tb_hamming74_rx_sequencer.sv
// Purpose: checks the Hamming(7,4) receive sequencer with vector tables, directed corner sequences and random frames.
// Latency: outputs are sampled on the falling edge after each stop-bit strobe.
// Backpressure: byte_ready is driven per frame and applied with the stop strobe where the same-edge case matters.
module tb_hamming74_rx_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hamming74_rx_sequencer_if bus ();

    hamming74_rx_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:1] cw_lo;
        logic [7:1] cw_hi;
        logic [7:0] exp_byte;
        logic       exp_corr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Systematic encoder: data bits at positions 3,5,6,7 and even-parity bits at 1,2,4
    function automatic logic [7:1] encode(input logic [3:0] d);
        logic [7:1] c;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    function automatic logic [7:1] flip(input logic [7:1] cw, input int pos);
        logic [7:1] c;
        c = cw;
        c[pos] = ~c[pos];
        return c;
    endfunction

    // Reference decode: the syndrome is the XOR of the positions of all set bits
    function automatic void ref_decode(input logic [7:1] cw, output logic [3:0] nib, output logic fixed);
        int s;
        logic [7:1] c;
        s = 0;
        c = cw;
        for (int i = 1; i <= 7; i++) begin
            if (c[i]) s = s ^ i;
        end
        if (s != 0) c[s] = ~c[s];
        nib   = {c[7], c[6], c[5], c[3]};
        fixed = (s != 0);
    endfunction

    task automatic send_bit(input logic b, input logic r);
        @(negedge clk);
        bus.rx_in      = b;
        bus.bit_en     = 1'b1;
        bus.byte_ready = r;
        @(negedge clk);
        bus.bit_en = 1'b0;
        bus.rx_in  = 1'b1;
    endtask

    // Start bit, c1..c7, stop bit; r_stop is the ready level on the stop strobe
    task automatic send_frame(input logic [7:1] cw, input logic stop, input logic r_stop);
        send_bit(1'b0, bus.byte_ready);
        for (int i = 1; i <= 7; i++) send_bit(cw[i], bus.byte_ready);
        send_bit(stop, r_stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.ena        = 1'b1;
        bus.bit_en     = 1'b0;
        bus.rx_in      = 1'b1;
        bus.byte_ready = 1'b0;
        rst_n          = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    // Watchdog so the run always ends
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic       m_valid, m_pend, m_corr, m_lo_corr, m_ferr, m_ovf;
    logic [7:0] m_byte;
    logic [3:0] m_lo, r_nib;
    logic       r_fix;

    initial begin
        vecs[0] = '{encode(4'h5),          encode(4'hA),          8'hA5, 1'b0};
        vecs[1] = '{flip(encode(4'h5), 6), encode(4'hA),          8'hA5, 1'b1};
        vecs[2] = '{flip(encode(4'h5), 1), encode(4'hA),          8'hA5, 1'b1};
        vecs[3] = '{encode(4'h0),          flip(encode(4'hF), 7), 8'hF0, 1'b1};
        vecs[4] = '{encode(4'hF),          encode(4'h0),          8'h0F, 1'b0};
        vecs[5] = '{encode(4'hC),          flip(encode(4'h3), 4), 8'h3C, 1'b1};

        do_reset();
        check("reset_byte_out",   bus.byte_out,   8'h00);
        check("reset_byte_valid", bus.byte_valid, 1'b0);
        check("reset_corrected",  bus.corrected,  1'b0);
        check("reset_frame_err",  bus.frame_err,  1'b0);
        check("reset_overflow",   bus.overflow,   1'b0);
        check("reset_busy",       bus.busy,       1'b0);

        // Line low in IDLE without a strobe is not a start bit
        bus.rx_in = 1'b0;
        idle(5);
        check("no_strobe_no_start_busy", bus.busy, 1'b0);
        bus.rx_in = 1'b1;
        idle(1);

        // Table: clean and single-error pairs with the consumer always ready
        bus.byte_ready = 1'b1;
        foreach (vecs[i]) begin
            send_frame(vecs[i].cw_lo, 1'b1, 1'b1);
            check($sformatf("vec%0d_lo_valid", i), bus.byte_valid, 1'b0);
            check($sformatf("vec%0d_lo_busy", i),  bus.busy,       1'b1);
            send_frame(vecs[i].cw_hi, 1'b1, 1'b1);
            check($sformatf("vec%0d_valid", i),    bus.byte_valid, 1'b1);
            check($sformatf("vec%0d_byte", i),     bus.byte_out,   vecs[i].exp_byte);
            check($sformatf("vec%0d_corr", i),     bus.corrected,  vecs[i].exp_corr);
            check($sformatf("vec%0d_ovf", i),      bus.overflow,   1'b0);
            check($sformatf("vec%0d_busy", i),     bus.busy,       1'b0);
            idle(1);
            check($sformatf("vec%0d_consumed", i), bus.byte_valid, 1'b0);
        end

        // Frame error discards the codeword and clears a pending low nibble
        send_frame(encode(4'h3), 1'b1, 1'b1);
        send_frame(encode(4'h5), 1'b0, 1'b1);
        check("ferr_pulse",     bus.frame_err,  1'b1);
        check("ferr_no_byte",   bus.byte_valid, 1'b0);
        check("ferr_busy",      bus.busy,       1'b0);
        idle(1);
        check("ferr_one_cycle", bus.frame_err,  1'b0);
        send_frame(encode(4'h5), 1'b1, 1'b1);
        send_frame(encode(4'hA), 1'b1, 1'b1);
        check("ferr_resync_byte",  bus.byte_out,   8'hA5);
        check("ferr_resync_valid", bus.byte_valid, 1'b1);
        check("ferr_resync_nferr", bus.frame_err,  1'b0);
        idle(1);

        // Back-pressure: second byte overflows, third loads on the consuming edge
        bus.byte_ready = 1'b0;
        send_frame(encode(4'h5), 1'b1, 1'b0);
        send_frame(encode(4'hA), 1'b1, 1'b0);
        check("bp_first_valid", bus.byte_valid, 1'b1);
        check("bp_first_byte",  bus.byte_out,   8'hA5);
        send_frame(encode(4'hA), 1'b1, 1'b0);
        send_frame(encode(4'h5), 1'b1, 1'b0);
        check("ovf_pulse",      bus.overflow,   1'b1);
        check("ovf_hold_byte",  bus.byte_out,   8'hA5);
        check("ovf_hold_valid", bus.byte_valid, 1'b1);
        idle(1);
        check("ovf_one_cycle",  bus.overflow,   1'b0);
        check("ovf_still_byte", bus.byte_out,   8'hA5);
        send_frame(encode(4'hC), 1'b1, 1'b0);
        send_frame(encode(4'h3), 1'b1, 1'b1);
        check("same_edge_load_byte",  bus.byte_out,   8'h3C);
        check("same_edge_load_valid", bus.byte_valid, 1'b1);
        check("same_edge_no_ovf",     bus.overflow,   1'b0);
        idle(1);
        check("same_edge_consumed",   bus.byte_valid, 1'b0);

        // Enable drop mid-frame loses the partial frame and the pending nibble
        send_frame(encode(4'h3), 1'b1, 1'b1);
        check("ena_pending_busy", bus.busy, 1'b1);
        send_bit(1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) send_bit(encode(4'h5) >> (i - 1), 1'b1);
        bus.ena = 1'b0;
        idle(2);
        check("ena_low_busy", bus.busy, 1'b0);
        bus.ena = 1'b1;
        send_frame(encode(4'h5), 1'b1, 1'b1);
        check("ena_lo_nferr", bus.frame_err, 1'b0);
        send_frame(encode(4'hA), 1'b1, 1'b1);
        check("ena_byte",  bus.byte_out,   8'hA5);
        check("ena_valid", bus.byte_valid, 1'b1);
        check("ena_nferr", bus.frame_err,  1'b0);
        idle(1);

        // Asynchronous reset mid-frame with a held corrected byte and a pending nibble
        bus.byte_ready = 1'b0;
        send_frame(flip(encode(4'h5), 2), 1'b1, 1'b0);
        send_frame(encode(4'hA), 1'b1, 1'b0);
        check("rst_pre_corr", bus.corrected, 1'b1);
        send_frame(encode(4'h3), 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) send_bit(encode(4'h6) >> (i - 1), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_byte_out",  bus.byte_out,   8'h00);
        check("rst_mid_valid",     bus.byte_valid, 1'b0);
        check("rst_mid_corrected", bus.corrected,  1'b0);
        check("rst_mid_busy",      bus.busy,       1'b0);
        idle(2);
        rst_n = 1'b1;
        send_frame(encode(4'h5), 1'b1, 1'b0);
        send_frame(encode(4'hA), 1'b1, 1'b1);
        check("rst_after_byte", bus.byte_out,   8'hA5);
        check("rst_after_corr", bus.corrected,  1'b0);
        check("rst_after_ovf",  bus.overflow,   1'b0);

        // Random frames against a frame-level reference model
        do_reset();
        m_valid = 1'b0; m_pend = 1'b0; m_corr = 1'b0; m_lo_corr = 1'b0;
        m_byte = 8'h00; m_lo = 4'h0;
        for (int n = 0; n < 300; n++) begin
            logic       r, stop;
            logic [3:0] d;
            logic [7:1] cw;
            int         p;
            r    = 1'($urandom_range(0, 1));
            d    = 4'($urandom_range(0, 15));
            p    = int'($urandom_range(0, 7));
            stop = ($urandom_range(0, 7) != 0);
            cw   = encode(d);
            if (p != 0) cw = flip(cw, p);
            bus.byte_ready = r;
            idle(int'($urandom_range(0, 2)));
            // A held byte is consumed during the frame whenever ready is high
            if (r && m_valid) m_valid = 1'b0;
            send_frame(cw, stop, r);
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
            if (!stop) begin
                m_ferr = 1'b1;
                m_pend = 1'b0;
            end else begin
                ref_decode(cw, r_nib, r_fix);
                if (!m_pend) begin
                    m_lo      = r_nib;
                    m_lo_corr = r_fix;
                    m_pend    = 1'b1;
                end else begin
                    m_pend = 1'b0;
                    if (!m_valid) begin
                        m_byte  = {r_nib, m_lo};
                        m_corr  = r_fix | m_lo_corr;
                        m_valid = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            check($sformatf("rnd%0d_ferr", n),  bus.frame_err,  m_ferr);
            check($sformatf("rnd%0d_ovf", n),   bus.overflow,   m_ovf);
            check($sformatf("rnd%0d_valid", n), bus.byte_valid, m_valid);
            check($sformatf("rnd%0d_byte", n),  bus.byte_out,   m_byte);
            check($sformatf("rnd%0d_corr", n),  bus.corrected,  m_corr);
            check($sformatf("rnd%0d_busy", n),  bus.busy,       m_pend);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
